// File: rtl/sort_engine_pkg.sv
// Shared definitions for the sort engine: FSM encoding and sizing helper.
package sort_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SORT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Phase counter width: must hold values up to N_ELEM without wrapping.
  function automatic int phase_w(input int n_elem);
    return $clog2(n_elem) + 1;
  endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Valid/ready job and result bus between array producer, sort engine and consumer.
interface sort_engine_if #(
  parameter int N_ELEM = 4,
  parameter int DATA_W = 4,
  parameter int IDX_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_ELEM*DATA_W-1:0] array_in;
  logic [IDX_W-1:0]         lo_ind;
  logic [IDX_W-1:0]         hi_ind;
  logic                     descend;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_ELEM*DATA_W-1:0] sorted_array;
  logic                     range_err;

  // Producer/consumer side.
  modport master (
    output in_valid, array_in, lo_ind, hi_ind, descend, out_ready,
    input  in_ready, out_valid, sorted_array, range_err
  );

  // Engine side.
  modport slave (
    input  in_valid, array_in, lo_ind, hi_ind, descend, out_ready,
    output in_ready, out_valid, sorted_array, range_err
  );
endinterface

// File: rtl/sort_engine_cmp_swap.sv
// One compare-exchange cell: orders a pair for the requested direction.
module sort_engine_cmp_swap #(
  parameter int DATA_W = 4
) (
  input  logic              descend,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] hi_out,
  output logic              swapped
);
  // Equal values never swap, which keeps the sort stable.
  always_comb begin
    swapped = descend ? (a < b) : (a > b);
    lo_out  = swapped ? b : a;
    hi_out  = swapped ? a : b;
  end
endmodule

// File: rtl/sort_engine.sv
// Odd-even transposition sorter over a clamped sub-range, one phase per clock.
module sort_engine
  import sort_engine_pkg::*;
#(
  parameter int N_ELEM = 4,
  parameter int DATA_W = 4,
  parameter int IDX_W  = 4
) (
  input logic          clk,
  input logic          rst,
  sort_engine_if.slave bus
);
  localparam int               PW      = phase_w(N_ELEM);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N_ELEM - 1);

  state_t                        state_reg, state_next;
  logic [N_ELEM-1:0][DATA_W-1:0] arr_reg, arr_next;
  logic [IDX_W-1:0]              lo_reg, hi_reg;
  logic [PW-1:0]                 len_reg, phase_reg;
  logic                          desc_reg, err_reg, prev_quiet_reg;

  logic                          accept, any_swap, sort_exit;
  logic [IDX_W-1:0]              hi_clamp;
  logic                          cap_err;
  logic [PW-1:0]                 cap_len;
  logic [N_ELEM-2:0]             pair_act, pair_swp;
  logic [N_ELEM-2:0][DATA_W-1:0] pair_lo, pair_hi;

  // Range evaluation of the offered job; an empty range yields length 0.
  always_comb begin
    hi_clamp = (bus.hi_ind > MAX_IDX) ? MAX_IDX : bus.hi_ind;
    cap_err  = (bus.hi_ind > MAX_IDX) || (bus.lo_ind > hi_clamp);
    cap_len  = (bus.lo_ind > hi_clamp) ? '0 :
               PW'({1'b0, hi_clamp} - {1'b0, bus.lo_ind} + (IDX_W+1)'(1));
  end

  // Pair (gi, gi+1) is active when inside the range and its parity matches the phase.
  for (genvar gi = 0; gi < N_ELEM - 1; gi++) begin : g_pair
    localparam logic GI_ODD = ((gi % 2) == 1);
    logic swp;

    sort_engine_cmp_swap #(.DATA_W(DATA_W)) u_cs (
      .descend (desc_reg),
      .a       (arr_reg[gi]),
      .b       (arr_reg[gi+1]),
      .lo_out  (pair_lo[gi]),
      .hi_out  (pair_hi[gi]),
      .swapped (swp)
    );

    assign pair_act[gi] = !(lo_reg > IDX_W'(gi)) && !(IDX_W'(gi + 1) > hi_reg) &&
                          ((lo_reg[0] ^ phase_reg[0]) == GI_ODD);
    assign pair_swp[gi] = pair_act[gi] & swp;
  end

  // Each element takes the result of the active pair covering it, else holds.
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
    if (gi == 0) begin : g_first
      assign arr_next[gi] = pair_act[0] ? pair_lo[0] : arr_reg[gi];
    end else if (gi == N_ELEM - 1) begin : g_last
      assign arr_next[gi] = pair_act[gi-1] ? pair_hi[gi-1] : arr_reg[gi];
    end else begin : g_mid
      assign arr_next[gi] = pair_act[gi-1] ? pair_hi[gi-1] :
                            (pair_act[gi] ? pair_lo[gi] : arr_reg[gi]);
    end
  end

  assign any_swap  = |pair_swp;
  assign sort_exit = (phase_reg + PW'(1) == len_reg) ||
                     ((phase_reg != '0) && prev_quiet_reg && !any_swap);
  assign accept    = (state_reg == ST_IDLE) && bus.in_valid;

  assign bus.sorted_array = arr_reg;
  assign bus.range_err    = err_reg && (state_reg == ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ST_LOAD;
      end
      ST_LOAD: state_next = (len_reg <= PW'(1)) ? ST_DONE : ST_SORT;
      ST_SORT: if (sort_exit) state_next = ST_DONE;
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Job capture and one compare-exchange phase per SORT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_reg        <= '0;
      lo_reg         <= '0;
      hi_reg         <= '0;
      len_reg        <= '0;
      phase_reg      <= '0;
      desc_reg       <= 1'b0;
      err_reg        <= 1'b0;
      prev_quiet_reg <= 1'b0;
    end else if (accept) begin
      arr_reg        <= bus.array_in;
      lo_reg         <= bus.lo_ind;
      hi_reg         <= hi_clamp;
      len_reg        <= cap_len;
      phase_reg      <= '0;
      desc_reg       <= bus.descend;
      err_reg        <= cap_err;
      prev_quiet_reg <= 1'b0;
    end else if (state_reg == ST_SORT) begin
      arr_reg        <= arr_next;
      phase_reg      <= phase_reg + PW'(1);
      prev_quiet_reg <= !any_swap;
    end
  end
endmodule
